// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared encodings for the stage-4 memory controller
// Purpose: MemOp encodings, MUXY select constants, controller state enum and
//          the op-to-writeback decode helpers.
// Ports:   none (package).
package processor_pkg;

  localparam logic [1:0] MEMOP_NONE  = 2'b00;
  localparam logic [1:0] MEMOP_LOAD  = 2'b01;
  localparam logic [1:0] MEMOP_STORE = 2'b10;
  localparam logic [1:0] MEMOP_CALL  = 2'b11;

  localparam logic [1:0] YSEL_RETADDR = 2'd0;
  localparam logic [1:0] YSEL_MEM     = 2'd1;
  localparam logic [1:0] YSEL_RZ      = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  function automatic logic [1:0] ysel_for(input logic [1:0] op);
    case (op)
      MEMOP_LOAD: return YSEL_MEM;
      MEMOP_CALL: return YSEL_RETADDR;
      default:    return YSEL_RZ;
    endcase
  endfunction

  // Only STORE skips write-back; a faulted LOAD is cleared later by the FSM.
  function automatic logic rf_write_for(input logic [1:0] op);
    return op != MEMOP_STORE;
  endfunction

endpackage

// File: rtl/memory_stage_controller_if.sv
// rtl/memory_stage_controller_if.sv - RAM bus between stage 4 and memory
// Purpose: groups the RAM address/data/strobe/MFC signals.
// Ports:   master = controller (drives address, store data, strobes);
//          slave  = RAM (drives read data and MFC).
interface memory_stage_controller_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] MEM_Address;
  logic [DATA_WIDTH-1:0] MEM_DataOut;
  logic [DATA_WIDTH-1:0] MEM_DataIn;
  logic                  MEM_Read;
  logic                  MEM_Write;
  logic                  MFC;

  modport master (
    output MEM_Address, MEM_DataOut, MEM_Read, MEM_Write,
    input  MEM_DataIn, MFC
  );

  modport slave (
    input  MEM_Address, MEM_DataOut, MEM_Read, MEM_Write,
    output MEM_DataIn, MFC
  );

endinterface

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - saturating MFC-wait counter
// Purpose: counts ACCESS cycles without MFC, saturating at TIMEOUT.
// Ports:   Clock, Reset (sync, active-high); clear restarts from zero;
//          enable counts one miss cycle; at_limit is high while the count
//          sits one below TIMEOUT, i.e. the current miss is the last allowed.
module timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
  localparam logic [W-1:0] LAST  = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

  assign at_limit = (count == LAST);

endmodule

// File: rtl/memory_stage_controller.sv
// rtl/memory_stage_controller.sv - stage-4 load/store controller with MFC handshake
// Purpose: latches the op on Start, runs one RAM access, stalls the step
//          counter until MFC or timeout, then presents MUXY select and
//          register-file write enable for stage 5.
// Ports:   Clock, Reset (sync, active-high); Start, MemOp, RZ, RM from execute;
//          mem = RAM bus (master); Memory_Data, Y_Select, RF_WRITE to
//          write-back; Stall, Done, Fault status.
module memory_stage_controller
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [1:0]            MemOp,
  input  logic [DATA_WIDTH-1:0] RZ,
  input  logic [DATA_WIDTH-1:0] RM,
  memory_stage_controller_if.master mem,
  output logic [DATA_WIDTH-1:0] Memory_Data,
  output logic [1:0]            Y_Select,
  output logic                  RF_WRITE,
  output logic                  Stall,
  output logic                  Done,
  output logic                  Fault
);

  mem_state_e state, state_next;

  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  read_c, write_c, stall_c, done_c;
  logic                  accept, access_op, at_limit, miss, timed_out;

  assign accept    = (state == ST_IDLE) && Start;
  assign access_op = (MemOp == MEMOP_LOAD) || (MemOp == MEMOP_STORE);
  assign miss      = (state == ST_ACCESS) && !mem.MFC;
  // MFC on the last allowed cycle still wins over the timeout.
  assign timed_out = miss && at_limit;

  timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (accept),
    .enable   (miss),
    .at_limit (at_limit)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    read_c     = 1'b0;
    write_c    = 1'b0;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) state_next = access_op ? ST_ACCESS : ST_DONE;
      end
      ST_ACCESS: begin
        stall_c = 1'b1;
        read_c  = (op_q == MEMOP_LOAD);
        write_c = (op_q == MEMOP_STORE);
        if (mem.MFC || at_limit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      op_q        <= MEMOP_NONE;
      addr_q      <= '0;
      dout_q      <= '0;
      Memory_Data <= '0;
      Y_Select    <= YSEL_RZ;
      RF_WRITE    <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      if (accept) begin
        op_q     <= MemOp;
        addr_q   <= RZ;
        dout_q   <= RM;
        Y_Select <= ysel_for(MemOp);
        RF_WRITE <= rf_write_for(MemOp);
        Fault    <= 1'b0;
      end
      if ((state == ST_ACCESS) && mem.MFC && (op_q == MEMOP_LOAD)) begin
        Memory_Data <= mem.MEM_DataIn;
      end
      if (timed_out) begin
        Fault    <= 1'b1;
        RF_WRITE <= 1'b0;
      end
    end
  end

  assign mem.MEM_Address = addr_q;
  assign mem.MEM_DataOut = dout_q;
  assign mem.MEM_Read    = read_c;
  assign mem.MEM_Write   = write_c;
  assign Stall           = stall_c;
  assign Done            = done_c;

endmodule

// File: tb/tb_memory_stage_controller.sv
// tb/tb_memory_stage_controller.sv - self-checking bench for memory_stage_controller
module tb_memory_stage_controller;
  import processor_pkg::*;

  localparam int DW = 32;
  localparam int TO = 15;
  localparam int NEVER = 1000;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic [1:0]    MemOp;
  logic [DW-1:0] RZ;
  logic [DW-1:0] RM;
  logic [DW-1:0] Memory_Data;
  logic [1:0]    Y_Select;
  logic          RF_WRITE;
  logic          Stall;
  logic          Done;
  logic          Fault;

  int checks = 0;
  int errors = 0;

  // reference model state: last successfully loaded word and sticky fault
  logic [DW-1:0] m_mem;
  logic          m_fault;

  memory_stage_controller_if #(.DATA_WIDTH(DW)) mem_bus ();

  memory_stage_controller #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .MemOp       (MemOp),
    .RZ          (RZ),
    .RM          (RM),
    .mem         (mem_bus),
    .Memory_Data (Memory_Data),
    .Y_Select    (Y_Select),
    .RF_WRITE    (RF_WRITE),
    .Stall       (Stall),
    .Done        (Done),
    .Fault       (Fault)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_stall"}, Stall, 0);
    check({tag, "_done"}, Done, 0);
    check({tag, "_rd"}, mem_bus.MEM_Read, 0);
    check({tag, "_wr"}, mem_bus.MEM_Write, 0);
    check({tag, "_fault"}, Fault, 0);
    check({tag, "_addr"}, mem_bus.MEM_Address, 0);
    check({tag, "_dout"}, mem_bus.MEM_DataOut, 0);
    check({tag, "_mdata"}, Memory_Data, 0);
    check({tag, "_ysel"}, Y_Select, 2);
    check({tag, "_rfw"}, RF_WRITE, 0);
  endtask

  // One instruction. k = MFC latency in ACCESS cycles (NEVER = no MFC).
  // noise adds ignored Start/MFC activity outside IDLE/ACCESS respectively.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [DW-1:0] rz,
                         input logic [DW-1:0] rm, input logic [DW-1:0] din,
                         input int k, input bit noise);
    bit acc, faulted;
    int done_at;
    logic [1:0] exp_ysel;
    bit exp_rfw;
    acc     = (op == MEMOP_LOAD) || (op == MEMOP_STORE);
    faulted = acc && (k >= TO);
    done_at = !acc ? 1 : (faulted ? TO + 1 : k + 2);
    case (op)
      MEMOP_NONE:  begin exp_ysel = 2'd2; exp_rfw = 1'b1; end
      MEMOP_LOAD:  begin exp_ysel = 2'd1; exp_rfw = !faulted; end
      MEMOP_STORE: begin exp_ysel = 2'd2; exp_rfw = 1'b0; end
      default:     begin exp_ysel = 2'd0; exp_rfw = 1'b1; end
    endcase

    Start = 1'b1;
    MemOp = op;
    RZ    = rz;
    RM    = rm;
    mem_bus.MFC = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_bus.MEM_DataIn = $urandom;
    step();

    for (int j = 1; j <= done_at; j++) begin
      check({tag, "_stall"}, Stall, acc && (j < done_at));
      check({tag, "_rd"}, mem_bus.MEM_Read, (op == MEMOP_LOAD) && (j < done_at));
      check({tag, "_wr"}, mem_bus.MEM_Write, (op == MEMOP_STORE) && (j < done_at));
      check({tag, "_done"}, Done, j == done_at);
      check({tag, "_fault"}, Fault, faulted && (j == done_at));
      if (j == done_at) begin
        if ((op == MEMOP_LOAD) && !faulted) m_mem = din;
        m_fault = faulted;
        check({tag, "_mdata"}, Memory_Data, m_mem);
        check({tag, "_ysel"}, Y_Select, exp_ysel);
        check({tag, "_rfw"}, RF_WRITE, exp_rfw);
        check({tag, "_addr"}, mem_bus.MEM_Address, rz);
        check({tag, "_dout"}, mem_bus.MEM_DataOut, rm);
      end
      if (acc && (j - 1 == k)) begin
        mem_bus.MFC = 1'b1;
        mem_bus.MEM_DataIn = din;
      end else begin
        mem_bus.MFC = noise && (j == done_at) && 1'($urandom_range(0, 1));
        mem_bus.MEM_DataIn = $urandom;
      end
      Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      MemOp = 2'($urandom_range(0, 3));
      RZ    = $urandom;
      RM    = $urandom;
      step();
    end

    Start = 1'b0;
    mem_bus.MFC = 1'b0;
    check({tag, "_idle_done"}, Done, 0);
    check({tag, "_idle_stall"}, Stall, 0);
    check({tag, "_idle_fault"}, Fault, m_fault);
    check({tag, "_idle_ysel"}, Y_Select, exp_ysel);
    check({tag, "_idle_rfw"}, RF_WRITE, exp_rfw);

    if (noise) begin
      mem_bus.MFC = 1'b1;
      mem_bus.MEM_DataIn = $urandom;
      step();
      mem_bus.MFC = 1'b0;
      check({tag, "_stray_mfc_mdata"}, Memory_Data, m_mem);
      check({tag, "_stray_mfc_stall"}, Stall, 0);
      check({tag, "_stray_mfc_done"}, Done, 0);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    MemOp = MEMOP_NONE;
    RZ    = '0;
    RM    = '0;
    mem_bus.MFC = 1'b0;
    mem_bus.MEM_DataIn = '0;
    m_mem   = '0;
    m_fault = 1'b0;
    step();
    step();
    check_reset_values("reset");
    Reset = 1'b0;
    step();

    run_txn("load_k2", MEMOP_LOAD, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    run_txn("store_k0", MEMOP_STORE, 32'h0000_0010, 32'h1234_5678, 32'hCAFE_F00D, 0, 1'b0);
    run_txn("none", MEMOP_NONE, 32'h0000_0077, 32'h0, 32'h0, 0, 1'b0);
    run_txn("call", MEMOP_CALL, 32'h0000_0088, 32'h0, 32'h0, 0, 1'b0);
    run_txn("load_timeout", MEMOP_LOAD, 32'h0000_0100, 32'h0, 32'h5555_AAAA, NEVER, 1'b0);
    run_txn("store_last_mfc", MEMOP_STORE, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0, TO - 1, 1'b0);
    run_txn("load_noise", MEMOP_LOAD, 32'h0000_0300, 32'h0, 32'h0BAD_CAFE, 1, 1'b1);

    // LOAD interrupted by Reset during its second ACCESS cycle, with a
    // stray Start in the first
    Start = 1'b1;
    MemOp = MEMOP_LOAD;
    RZ    = 32'h0000_0400;
    RM    = 32'h1111_2222;
    step();
    Start = 1'b1;
    MemOp = MEMOP_CALL;
    step();
    Start = 1'b0;
    check("rst_mid_stall", Stall, 1);
    check("rst_mid_rd", mem_bus.MEM_Read, 1);
    check("rst_mid_ysel", Y_Select, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_mem   = '0;
    m_fault = 1'b0;
    check_reset_values("rst_mid");
    step();

    for (int n = 0; n < 60; n++) begin
      logic [1:0] op;
      int k;
      op = 2'($urandom_range(0, 3));
      k  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
      run_txn("rand", op, $urandom, $urandom, $urandom, k, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage_controller.md
# memory_stage_controller

Multi-cycle memory-access controller for stage 4 of the processor datapath. It sits between the execute registers (RZ, RM) and the write-back mux (MUXY), and performs one RAM load or store per instruction using an MFC (memory-function-complete) handshake. It holds the stage step counter via `Stall` until the access finishes, then returns the MUXY select and register-file write enable for stage 5.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of address, store data and load data.
- `TIMEOUT`, 15: maximum consecutive ACCESS cycles without MFC before fault; range 1..255.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Start` in 1: stage-4 strobe from the step counter; honoured only in IDLE.
- `MemOp` in 2: 00 NONE, 01 LOAD, 10 STORE, 11 CALL.
- `RZ` in DATA_WIDTH: effective address (LOAD/STORE) or ALU result.
- `RM` in DATA_WIDTH: store data.
- `MEM_DataIn` in DATA_WIDTH: RAM read data.
- `MFC` in 1: RAM completion, level-sampled.
- `MEM_Address` out DATA_WIDTH: registered address.
- `MEM_DataOut` out DATA_WIDTH: registered store data.
- `MEM_Read` out 1: read strobe.
- `MEM_Write` out 1: write strobe.
- `Memory_Data` out DATA_WIDTH: captured load data, feeds MUXY input 1.
- `Y_Select` out 2: MUXY select; 2 = RZ, 1 = Memory_Data, 0 = Return_Address.
- `RF_WRITE` out 1: write-back enable for stage 5.
- `Stall` out 1: high while an access is in progress.
- `Done` out 1: one-cycle completion pulse.
- `Fault` out 1: timeout flag.

## Operation
- States are IDLE, ACCESS and DONE. Encoding lives in the package.
- In IDLE, `Start` latches `MemOp`, `RZ` into `MEM_Address`, and `RM` into `MEM_DataOut`. It also clears `Fault` and the timeout counter.
  - LOAD or STORE goes to ACCESS.
  - NONE or CALL goes to DONE.
- In ACCESS:
  - `MEM_Read` is high for LOAD; `MEM_Write` is high for STORE. The other strobe is 0.
  - `Stall` is 1.
  - If `MFC` = 1, a LOAD captures `MEM_DataIn` into `Memory_Data`, and the state goes to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT, the state goes to DONE, `Fault` is set, and `Memory_Data` is unchanged.
- In DONE, `Done` is 1 for one cycle, and the state returns to IDLE unconditionally.
- `Y_Select` and `RF_WRITE` are registered from the latched op and held until the next `Start`:
  - NONE: Y_Select 2, RF_WRITE 1.
  - LOAD: Y_Select 1, RF_WRITE 1; RF_WRITE is 0 if the access faulted.
  - STORE: Y_Select 2, RF_WRITE 0.
  - CALL: Y_Select 0, RF_WRITE 1.
- `Start` outside IDLE is ignored, including `Start` in DONE. `MFC` outside ACCESS is ignored.
- `Fault` is sticky until the next accepted `Start` or `Reset`.
- Timeout counter width is `$clog2(TIMEOUT+1)`. It never wraps, because it saturates at TIMEOUT.

## Timing
- Reset values: state IDLE; `MEM_Read`, `MEM_Write`, `Stall`, `Done`, `Fault` = 0; `MEM_Address`, `MEM_DataOut`, `Memory_Data` = 0; `Y_Select` = 2; `RF_WRITE` = 0.
- Reset asserted mid-ACCESS returns all outputs to reset values at the next edge. The strobe drops in the same cycle `Reset` is sampled.
- NONE/CALL: `Start` sampled at edge t gives `Done` during cycle t+1.
- LOAD/STORE: strobes are high from cycle t+1. If `MFC` is first high in cycle t+1+k, with k ≥ 0:
  - strobes drop after that cycle;
  - `Memory_Data` is valid from cycle t+2+k;
  - `Done` is high in cycle t+2+k.
- Minimum memory latency is 2 cycles, for `MFC` in the same cycle as the strobe.
- Timeout: no `MFC` for TIMEOUT ACCESS cycles puts `Done` and `Fault` high in cycle t+1+TIMEOUT.
- `Stall` equals the ACCESS-state decode and is low in DONE.

## Structure
- Package `processor_pkg` holds:
  - MemOp encodings: `MEMOP_NONE`, `MEMOP_LOAD`, `MEMOP_STORE`, `MEMOP_CALL`;
  - Y_Select constants: `YSEL_RETADDR`, `YSEL_MEM`, `YSEL_RZ`;
  - the state enum.
- One sub-module, `timeout_counter`: saturating counter with clear, enable and an at-limit output, parameterised by TIMEOUT.
- Everything else is one FSM plus output registers in `memory_stage_controller`.

## Test plan
- Reset, then LOAD with RZ = 0x00000040, RAM returns 0xDEADBEEF with MFC at k = 2 → MEM_Read high for cycles t+1..t+3, Done at t+4, Memory_Data = 0xDEADBEEF, Y_Select = 1, RF_WRITE = 1.
- STORE with RZ = 0x10, RM = 0x12345678, MFC at k = 0 → MEM_Write high only in cycle t+1, MEM_DataOut = 0x12345678, Done at t+2, RF_WRITE = 0, Memory_Data unchanged.
- NONE then CALL → Done at t+1 each, no strobes; Y_Select = 2 then 0; RF_WRITE = 1.
- LOAD with MFC never asserted and TIMEOUT = 15 → Done and Fault at t+16, RF_WRITE = 0; the next Start clears Fault.
- Start pulsed during ACCESS, MFC pulsed in IDLE, and Reset asserted at k = 1 of a LOAD → extra Start ignored, stray MFC ignored, Reset returns all outputs to reset values at the next edge.
